// File: rtl/full_subtractor_pkg.sv
// rtl/full_subtractor_pkg.sv - shared constants and golden reference for the ripple-borrow subtractor
package full_subtractor_pkg;

    localparam int FS_MAX_WIDTH = 64;

    // Returns {borrow, diff} in the low width+1 bits; higher bits are zero.
    function automatic logic [FS_MAX_WIDTH:0] fs_ref(
        input logic [FS_MAX_WIDTH-1:0] a,
        input logic [FS_MAX_WIDTH-1:0] b,
        input logic                    c,
        input int                      width
    );
        logic [FS_MAX_WIDTH:0] full;
        logic [FS_MAX_WIDTH:0] mask;
        full = {1'b0, a} - {1'b0, b} - {{FS_MAX_WIDTH{1'b0}}, c};
        mask = ((FS_MAX_WIDTH+1)'(1) << (width + 1)) - (FS_MAX_WIDTH+1)'(1);
        return full & mask;
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - combinational 1-bit full-subtractor cell
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - registered ripple-borrow a-b-c subtractor; FULL_SUBTRACTOR_OVF_EN adds signed overflow output ovf
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    output logic [WIDTH-1:0] difference,
    output logic             barrow
`ifdef FULL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   borrow_chain;
    logic [WIDTH-1:0] diff_comb;

    assign borrow_chain[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor_bit u_bit (
            .a   (a[i]),
            .b   (b[i]),
            .bin (borrow_chain[i]),
            .d   (diff_comb[i]),
            .bout(borrow_chain[i+1])
        );
    end

    // Result registers only load on a valid capture; out_valid tracks in_valid every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            difference <= '0;
            barrow     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                difference <= diff_comb;
                barrow     <= borrow_chain[WIDTH];
            end
        end
    end

`ifdef FULL_SUBTRACTOR_OVF_EN
    // Signed overflow: borrow into the sign bit differs from borrow out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= borrow_chain[WIDTH-1] ^ borrow_chain[WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// tb/tb_full_subtractor.sv - scoreboard bench for full_subtractor at WIDTH 1, 8 and 16
`timescale 1ns/1ps
module tb_full_subtractor;

    typedef struct packed {
        logic [63:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v1, v8, v16;
    logic [0:0]  a1, b1, d1;
    logic [7:0]  a8, b8, d8;
    logic [15:0] a16, b16, d16;
    logic        c1, c8, c16;
    logic        ov1, ov8, ov16;
    logic        bo1, bo8, bo16;
    logic        f1, f8, f16;

`ifndef FULL_SUBTRACTOR_OVF_EN
    assign f1  = 1'b0;
    assign f8  = 1'b0;
    assign f16 = 1'b0;
`endif

    full_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1),
        .out_valid(ov1), .difference(d1), .barrow(bo1)
`ifdef FULL_SUBTRACTOR_OVF_EN
        , .ovf(f1)
`endif
    );

    full_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8),
        .out_valid(ov8), .difference(d8), .barrow(bo8)
`ifdef FULL_SUBTRACTOR_OVF_EN
        , .ovf(f8)
`endif
    );

    full_subtractor #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .c(c16),
        .out_valid(ov16), .difference(d16), .barrow(bo16)
`ifdef FULL_SUBTRACTOR_OVF_EN
        , .ovf(f16)
`endif
    );

    exp_t sbq[3][$];
    exp_t last_exp[3];
    int   tests = 0;
    int   fails = 0;
    bit   running = 1'b0;

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic c);
        exp_t   e;
        longint m, ua, ub, uc, r, sa, sb, sr;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        uc = c ? 1 : 0;
        r  = ua - ub - uc;
        e.d  = 64'(((r % m) + m) % m);
        e.bo = (ua < ub + uc);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sr = sa - sb - uc;
        e.ov = (sr < -(m / 2)) || (sr >= m / 2);
        return e;
    endfunction

    task automatic cmp(string nm, exp_t e, logic [63:0] d, logic bo, logic f);
        bit bad;
        tests++;
        bad = (d !== e.d) || (bo !== e.bo);
`ifdef FULL_SUBTRACTOR_OVF_EN
        bad = bad || (f !== e.ov);
`endif
        if (bad) begin
            fails++;
            $display("FAIL %s: got d=%h borrow=%b ovf=%b, expected d=%h borrow=%b ovf=%b",
                     nm, d, bo, f, e.d, e.bo, e.ov);
        end
    endtask

    task automatic check(int i, string nm, logic ov, logic [63:0] d, logic bo, logic f);
        exp_t e;
        if (ov) begin
            if (sbq[i].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s: out_valid=1 with no expected result queued", nm);
            end else begin
                e = sbq[i].pop_front();
                last_exp[i] = e;
                cmp(nm, e, d, bo, f);
            end
        end else begin
            cmp({nm, "_hold"}, last_exp[i], d, bo, f);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            check(0, "w1", ov1, 64'(d1), bo1, f1);
            check(1, "w8", ov8, 64'(d8), bo8, f8);
            check(2, "w16", ov16, 64'(d16), bo16, f16);
        end
    end

    task automatic drive(int i, logic v, logic [63:0] a, logic [63:0] b, logic c, exp_t e);
        case (i)
            0: begin v1 = v; a1 = a[0:0]; b1 = b[0:0]; c1 = c; end
            1: begin v8 = v; a8 = a[7:0]; b8 = b[7:0]; c8 = c; end
            default: begin v16 = v; a16 = a[15:0]; b16 = b[15:0]; c16 = c; end
        endcase
        if (v) sbq[i].push_back(e);
    endtask

    task automatic drive_m(int i, logic v, logic [63:0] a, logic [63:0] b, logic c);
        int w;
        w = (i == 0) ? 1 : (i == 1) ? 8 : 16;
        drive(i, v, a, b, c, model(w, a, b, c));
    endtask

    // Directed vector: difference/borrow from constants, ovf from the model.
    task automatic drive_k(int i, logic [63:0] a, logic [63:0] b, logic c, logic [63:0] d, logic bo);
        exp_t e;
        int   w;
        w = (i == 0) ? 1 : (i == 1) ? 8 : 16;
        e = model(w, a, b, c);
        e.d  = d;
        e.bo = bo;
        drive(i, 1'b1, a, b, c, e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v8 = 1'b0;
        v16 = 1'b0;
    endtask

    task automatic expect_zero(string nm, logic ov, logic [63:0] d, logic bo);
        tests++;
        if (ov !== 1'b0 || d !== 64'd0 || bo !== 1'b0) begin
            fails++;
            $display("FAIL %s: got out_valid=%b d=%h borrow=%b, expected all zero", nm, ov, d, bo);
        end
    endtask

    int exp_d1[8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    int exp_b1[8] = '{0, 1, 1, 1, 0, 0, 0, 1};

    initial begin
        rst = 1'b1;
        {v1, v8, v16} = '0;
        {a1, b1, c1, a8, b8, c8, a16, b16, c16} = '0;
        for (int i = 0; i < 3; i++) last_exp[i] = '0;
        running = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        expect_zero("reset_w1", ov1, 64'(d1), bo1);
        expect_zero("reset_w8", ov8, 64'(d8), bo8);
        expect_zero("reset_w16", ov16, 64'(d16), bo16);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            logic [2:0] abc;
            abc = 3'(k);
            cycle();
            drive_k(0, 64'(abc[2]), 64'(abc[1]), abc[0], 64'(exp_d1[k]), exp_b1[k][0]);
        end

        cycle(); drive_k(1, 64'h00, 64'h01, 1'b0, 64'hFF, 1'b1);
        cycle(); drive_k(1, 64'h5A, 64'h5A, 1'b1, 64'hFF, 1'b1);
        cycle(); drive_k(1, 64'hC8, 64'h32, 1'b0, 64'h96, 1'b0);
        cycle(); drive_k(2, 64'h1234, 64'h1234, 1'b0, 64'h0000, 1'b0);
        cycle(); drive_k(2, 64'h0000, 64'h0000, 1'b1, 64'hFFFF, 1'b1);
        cycle(); drive_k(2, 64'hFFFF, 64'hFFFF, 1'b1, 64'hFFFF, 1'b1);

`ifdef FULL_SUBTRACTOR_OVF_EN
        begin
            exp_t e;
            cycle();
            e.d = 64'h7F; e.bo = 1'b0; e.ov = 1'b1;
            drive(1, 1'b1, 64'h80, 64'h01, 1'b0, e);
            cycle();
            e.d = 64'h80; e.bo = 1'b1; e.ov = 1'b1;
            drive(1, 1'b1, 64'h7F, 64'hFF, 1'b0, e);
        end
`endif

        // Hold: one capture, then idle cycles with changing operands.
        cycle(); drive_k(1, 64'h10, 64'h01, 1'b0, 64'h0F, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            drive(1, 1'b0, 64'($urandom), 64'($urandom), 1'($urandom), '0);
        end

        // Reset mid-stream.
        for (int k = 0; k < 5; k++) begin
            cycle();
            drive_m(1, 1'b1, 64'($urandom), 64'($urandom), 1'($urandom));
        end
        cycle();
        drive_m(1, 1'b1, 64'($urandom), 64'($urandom), 1'($urandom));
        #2;
        rst = 1'b1;
        #1;
        expect_zero("midreset_w8", ov8, 64'(d8), bo8);
        for (int i = 0; i < 3; i++) begin
            sbq[i].delete();
            last_exp[i] = '0;
        end
        cycle();
        rst = 1'b0;
        drive_k(1, 64'h03, 64'h01, 1'b1, 64'h01, 1'b0);

        for (int k = 0; k < 10000; k++) begin
            cycle();
            drive_m(2, ($urandom_range(0, 9) != 0), 64'($urandom), 64'($urandom), 1'($urandom));
        end

        repeat (3) cycle();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (sbq[i].size() != 0) begin
                fails++;
                $display("FAIL drain_%0d: %0d results never presented, expected 0", i, sbq[i].size());
            end
        end
        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
